// File: rtl/addsub_pkg.sv
// Shared definitions for the accumulating 4-bit add/sub controller: state encoding,
// datapath width and the command/result payloads carried between pipeline stages.
package addsub_pkg;

    localparam int unsigned DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              m;
    } cmd_t;

    typedef struct packed {
        logic [DATA_W-1:0] sum;
        logic              carry;
        logic              ovf;
        logic              zero;
    } res_t;

    localparam res_t RES_RST = '{sum: '0, carry: 1'b0, ovf: 1'b0, zero: 1'b1};

endpackage

// File: rtl/addsub4bit.sv
// Combinational 4-bit ripple adder/subtractor: s = a + (b ^ {4{m}}) + m,
// exposing the carries into and out of the MSB for overflow detection.
module addsub4bit
    import addsub_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              m_i,
    output logic [DATA_W-1:0] sum_c,
    output logic              c3_c,
    output logic              c4_c
);

    logic [DATA_W-1:0] b_x;
    logic [DATA_W:0]   cy;

    always_comb begin
        b_x   = b_i ^ {DATA_W{m_i}};
        cy    = '0;
        sum_c = '0;
        cy[0] = m_i;
        for (int i = 0; i < int'(DATA_W); i++) begin
            sum_c[i] = a_i[i] ^ b_x[i] ^ cy[i];
            cy[i+1]  = (a_i[i] & b_x[i]) | (a_i[i] & cy[i]) | (b_x[i] & cy[i]);
        end
        c3_c = cy[DATA_W-1];
        c4_c = cy[DATA_W];
    end

endmodule

// File: rtl/addsub_acc_ctrl.sv
// Handshaked add/sub controller: accepts a command in IDLE, computes in EXEC,
// presents a registered result with flags in DONE until the consumer takes it.
module addsub_acc_ctrl
    import addsub_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              op_m,
    input  logic              op_acc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              ovf,
    output logic              zero,
    output logic [DATA_W-1:0] acc,
    output logic [CNT_W-1:0]  op_cnt
);

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    res_t              res_q, res_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [DATA_W-1:0] sum_c;
    logic              c3_c, c4_c;

    addsub4bit u_addsub (
        .a_i   (cmd_q.a),
        .b_i   (cmd_q.b),
        .m_i   (cmd_q.m),
        .sum_c (sum_c),
        .c3_c  (c3_c),
        .c4_c  (c4_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            res_q       <= RES_RST;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            res_q       <= res_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Handshake flags are registered copies of the next-state decode.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        res_d       = res_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cmd_d.a = op_acc ? acc_q : op_a;
                    cmd_d.b = op_b;
                    cmd_d.m = op_m;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d.sum   = sum_c;
                res_d.carry = c4_c;
                res_d.ovf   = c4_c ^ c3_c;
                res_d.zero  = (sum_c == '0);
                acc_d       = sum_c;
                cnt_d       = cnt_q + CNT_W'(1);
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = res_q.sum;
    assign carry     = res_q.carry;
    assign ovf       = res_q.ovf;
    assign zero      = res_q.zero;
    assign acc       = acc_q;
    assign op_cnt    = cnt_q;

endmodule
